// File: rtl/mem_bus_arbiter.sv
// Shares the single-ported system RAM between the CPU control path and the DMA/loader port.
// Round-robin grant on contention; each access runs 1+WAIT_STATES cycles followed by a one-cycle done.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_cycle,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_wait,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_done,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_wait,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned     WCNT_W    = 4;
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_STATES);
    localparam logic            OWN_CPU   = 1'b0;
    localparam logic            OWN_DMA   = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state, state_n;
    logic                owner, owner_n;
    logic                last, last_n;
    logic [WCNT_W-1:0]   wcnt, wcnt_n;
    logic                bus_we, bus_we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   wdata_n;
    logic [DATA_W-1:0]   cpu_rdata_n, dma_rdata_n;
    logic                cpu_gnt_n, dma_gnt_n, cpu_done_n, dma_done_n, mem_we_n;

    // Stall signals follow the live request until the done pulse arrives.
    assign cpu_wait = cpu_req & ~cpu_done;
    assign dma_wait = dma_req & ~dma_done;

    // Next-state, bus latch, read capture and registered-output decode.
    always_comb begin
        state_n     = state;
        owner_n     = owner;
        last_n      = last;
        wcnt_n      = wcnt;
        bus_we_n    = bus_we;
        addr_n      = mem_addr;
        wdata_n     = mem_wdata;
        cpu_rdata_n = cpu_rdata;
        dma_rdata_n = dma_rdata;

        case (state)
            S_IDLE: begin
                if (cpu_req || dma_req) begin
                    // Contention goes to whoever was not served last.
                    if (cpu_req && (!dma_req || last == OWN_DMA)) begin
                        owner_n  = OWN_CPU;
                        bus_we_n = cpu_we;
                        addr_n   = cpu_addr;
                        wdata_n  = cpu_wdata;
                    end else begin
                        owner_n  = OWN_DMA;
                        bus_we_n = dma_we;
                        addr_n   = dma_addr;
                        wdata_n  = dma_wdata;
                    end
                    wcnt_n  = WAIT_INIT;
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (wcnt == '0) begin
                    if (!bus_we) begin
                        if (owner == OWN_CPU) cpu_rdata_n = mem_rdata;
                        else                  dma_rdata_n = mem_rdata;
                    end
                    last_n  = owner;
                    state_n = S_DONE;
                end else begin
                    wcnt_n = wcnt - WCNT_W'(1);
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        cpu_gnt_n  = (state_n == S_ACCESS) && (owner_n == OWN_CPU);
        dma_gnt_n  = (state_n == S_ACCESS) && (owner_n == OWN_DMA);
        cpu_done_n = (state_n == S_DONE) && (owner_n == OWN_CPU);
        dma_done_n = (state_n == S_DONE) && (owner_n == OWN_DMA);
        mem_we_n   = (state_n == S_ACCESS) && bus_we_n;
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge reset_cycle) begin
        if (reset_cycle) begin
            state     <= S_IDLE;
            owner     <= OWN_CPU;
            last      <= OWN_DMA;
            wcnt      <= '0;
            bus_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            cpu_gnt   <= 1'b0;
            dma_gnt   <= 1'b0;
            cpu_done  <= 1'b0;
            dma_done  <= 1'b0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            last      <= last_n;
            wcnt      <= wcnt_n;
            bus_we    <= bus_we_n;
            mem_addr  <= addr_n;
            mem_wdata <= wdata_n;
            mem_we    <= mem_we_n;
            cpu_gnt   <= cpu_gnt_n;
            dma_gnt   <= dma_gnt_n;
            cpu_done  <= cpu_done_n;
            dma_done  <= dma_done_n;
            cpu_rdata <= cpu_rdata_n;
            dma_rdata <= dma_rdata_n;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: vector table, directed corner sequences and a randomized run
// checked cycle by cycle against a transaction-level timing/memory model.
module tb_mem_bus_arbiter;
    localparam int WS   = 1;
    localparam int MAXC = 512;

    logic       clk = 1'b0;
    logic       reset_cycle;
    logic       cpu_req, cpu_we, dma_req, dma_we;
    logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic       cpu_gnt, cpu_done, cpu_wait, dma_gnt, dma_done, dma_wait;
    logic [7:0] cpu_rdata, dma_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    logic       z_cpu_req, z_cpu_gnt, z_cpu_done, z_cpu_wait;
    logic       z_dma_gnt, z_dma_done, z_dma_wait, z_mem_we;
    logic [7:0] z_cpu_rdata, z_dma_rdata, z_mem_addr, z_mem_wdata, z_mem_rdata;

    logic [7:0] ram [256];
    logic [7:0] ram_img [256];
    logic [7:0] ref_mem [256];
    logic       ram_load = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_img[i];
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata   = ram[mem_addr];
    assign z_mem_rdata = z_mem_addr ^ 8'hDA;

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset_cycle(reset_cycle),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_wait(cpu_wait),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_done(dma_done), .dma_rdata(dma_rdata), .dma_wait(dma_wait),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) dut_ws0 (
        .clk(clk), .reset_cycle(reset_cycle),
        .cpu_req(z_cpu_req), .cpu_we(1'b0), .cpu_addr(8'h44), .cpu_wdata(8'h00),
        .cpu_gnt(z_cpu_gnt), .cpu_done(z_cpu_done), .cpu_rdata(z_cpu_rdata), .cpu_wait(z_cpu_wait),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(8'h00), .dma_wdata(8'h00),
        .dma_gnt(z_dma_gnt), .dma_done(z_dma_done), .dma_rdata(z_dma_rdata), .dma_wait(z_dma_wait),
        .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_we(z_mem_we), .mem_rdata(z_mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } op_t;

    op_t cq[$], dq[$];
    bit  c_act, d_act, c_dn, d_dn;
    int  order_q[$];

    // Transaction-level model: expected per-cycle outputs derived from arrival cycle and latency.
    bit         e_cg[MAXC], e_dg[MAXC], e_cd[MAXC], e_dd[MAXC], e_we[MAXC];
    bit         e_cru[MAXC], e_dru[MAXC];
    logic [7:0] e_crv[MAXC], e_drv[MAXC], e_addr[MAXC], e_wd[MAXC];
    logic [7:0] exp_crd, exp_drd;
    bit         last_dma;
    int         free_at;
    int         g_first, g_cnt, d_at, w_cnt;

    task automatic do_reset();
        reset_cycle = 1'b1;
        #1;
        cpu_req = 1'b0; dma_req = 1'b0; z_cpu_req = 1'b0;
        c_act = 0; d_act = 0; c_dn = 0; d_dn = 0;
        cq.delete(); dq.delete();
        last_dma = 1'b1; exp_crd = 8'h00; exp_drd = 8'h00;
        chk("rst_gnt", {30'd0, cpu_gnt, dma_gnt}, 32'd0);
        chk("rst_done", {30'd0, cpu_done, dma_done}, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
        chk("rst_rdata", {16'd0, cpu_rdata, dma_rdata}, 32'd0);
        ram_img = ref_mem;
        ram_load = 1'b1;
        @(posedge clk); #1;
        ram_load = 1'b0;
        @(negedge clk);
        reset_cycle = 1'b0;
    endtask

    task automatic run(input int ncyc, input bit eager);
        op_t        op;
        bit         pick, twe;
        logic [7:0] ta, twd;
        for (int i = 0; i < MAXC; i++) begin
            e_cg[i] = 0; e_dg[i] = 0; e_cd[i] = 0; e_dd[i] = 0; e_we[i] = 0;
            e_cru[i] = 0; e_dru[i] = 0; e_crv[i] = 0; e_drv[i] = 0; e_addr[i] = 0; e_wd[i] = 0;
        end
        free_at = 0; order_q.delete();
        g_first = -1; g_cnt = 0; d_at = -1; w_cnt = 0;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(posedge clk); #1;
            if (c_act && c_dn) begin c_act = 0; cpu_req = 1'b0; end
            if (d_act && d_dn) begin d_act = 0; dma_req = 1'b0; end
            if (!c_act && cq.size() > 0 && (eager || $urandom_range(0, 1) == 1)) begin
                op = cq.pop_front(); c_act = 1;
                cpu_req = 1'b1; cpu_we = op.we; cpu_addr = op.addr; cpu_wdata = op.wdata;
            end
            if (!d_act && dq.size() > 0 && (eager || $urandom_range(0, 1) == 1)) begin
                op = dq.pop_front(); d_act = 1;
                dma_req = 1'b1; dma_we = op.we; dma_addr = op.addr; dma_wdata = op.wdata;
            end
            @(negedge clk);
            if (cyc >= free_at && (cpu_req || dma_req)) begin
                pick = !(cpu_req && (!dma_req || last_dma));
                twe  = pick ? dma_we : cpu_we;
                ta   = pick ? dma_addr : cpu_addr;
                twd  = pick ? dma_wdata : cpu_wdata;
                for (int k = 1; k <= 1 + WS; k++) begin
                    if (pick) e_dg[cyc+k] = 1; else e_cg[cyc+k] = 1;
                    e_we[cyc+k] = twe; e_addr[cyc+k] = ta; e_wd[cyc+k] = twd;
                end
                if (pick) e_dd[cyc+2+WS] = 1; else e_cd[cyc+2+WS] = 1;
                if (twe) ref_mem[ta] = twd;
                else if (pick) begin e_dru[cyc+2+WS] = 1; e_drv[cyc+2+WS] = ref_mem[ta]; end
                else begin e_cru[cyc+2+WS] = 1; e_crv[cyc+2+WS] = ref_mem[ta]; end
                last_dma = pick;
                free_at  = cyc + 3 + WS;
            end
            if (e_cru[cyc]) exp_crd = e_crv[cyc];
            if (e_dru[cyc]) exp_drd = e_drv[cyc];
            chk("cpu_gnt", 32'(cpu_gnt), 32'(e_cg[cyc]));
            chk("dma_gnt", 32'(dma_gnt), 32'(e_dg[cyc]));
            chk("cpu_done", 32'(cpu_done), 32'(e_cd[cyc]));
            chk("dma_done", 32'(dma_done), 32'(e_dd[cyc]));
            chk("mem_we", 32'(mem_we), 32'(e_we[cyc]));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(exp_crd));
            chk("dma_rdata", 32'(dma_rdata), 32'(exp_drd));
            chk("cpu_wait", 32'(cpu_wait), 32'(cpu_req & ~e_cd[cyc]));
            chk("dma_wait", 32'(dma_wait), 32'(dma_req & ~e_dd[cyc]));
            chk("gnt_excl", 32'(cpu_gnt & dma_gnt), 32'd0);
            if (e_cg[cyc] || e_dg[cyc]) chk("mem_addr", 32'(mem_addr), 32'(e_addr[cyc]));
            if (e_we[cyc]) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[cyc]));
            if ((cpu_gnt || dma_gnt) && g_first < 0) g_first = cyc;
            if (cpu_gnt || dma_gnt) g_cnt++;
            if ((cpu_done || dma_done) && d_at < 0) d_at = cyc;
            if (mem_we) w_cnt++;
            if (cpu_done) order_q.push_back(0);
            if (dma_done) order_q.push_back(1);
            c_dn = cpu_done; d_dn = dma_done;
        end
    endtask

    typedef struct {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] crd;
        logic [7:0] drd;
        int         wecnt;
    } vec_t;

    vec_t tbl[7];
    int   exp_ord[6];
    op_t  rop;
    bit   zdn;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00, 0};
        tbl[1] = '{1'b1, 1'b1, 8'h80, 8'h3C, 8'hA5, 8'h00, 2};
        tbl[2] = '{1'b0, 1'b0, 8'h80, 8'h00, 8'h3C, 8'h00, 0};
        tbl[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 8'hA5, 0};
        tbl[4] = '{1'b0, 1'b1, 8'h10, 8'h55, 8'h3C, 8'hA5, 2};
        tbl[5] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 8'h55, 0};
        tbl[6] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h55, 8'h55, 0};
        exp_ord = '{0, 1, 0, 1, 0, 1};
        cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'hA5;
        ref_mem[8'h80] = 8'h00;
        do_reset();

        // Isolated single transactions with hand-computed results and latencies.
        for (int v = 0; v < 7; v++) begin
            if (tbl[v].port) dq.push_back({tbl[v].we, tbl[v].addr, tbl[v].wdata});
            else             cq.push_back({tbl[v].we, tbl[v].addr, tbl[v].wdata});
            run(6, 1'b1);
            chk($sformatf("tbl%0d_cpu_rdata", v), 32'(cpu_rdata), 32'(tbl[v].crd));
            chk($sformatf("tbl%0d_dma_rdata", v), 32'(dma_rdata), 32'(tbl[v].drd));
            chk($sformatf("tbl%0d_we_cycles", v), 32'(w_cnt), 32'(tbl[v].wecnt));
            chk($sformatf("tbl%0d_gnt_first", v), 32'(g_first), 32'd1);
            chk($sformatf("tbl%0d_gnt_cycles", v), 32'(g_cnt), 32'd2);
            chk($sformatf("tbl%0d_done_at", v), 32'(d_at), 32'd3);
        end

        // Simultaneous requests right after reset: CPU first, DMA next.
        do_reset();
        cq.push_back({1'b0, 8'h10, 8'h00});
        dq.push_back({1'b0, 8'h80, 8'h00});
        run(12, 1'b1);
        chk("contend_count", 32'(order_q.size()), 32'd2);
        for (int i = 0; i < order_q.size() && i < 2; i++)
            chk($sformatf("contend_order%0d", i), 32'(order_q[i]), 32'(exp_ord[i]));

        // Both ports hold requests continuously for six transactions.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cq.push_back({1'b1, 8'(8'h40 + i), 8'(8'hC0 + i)});
            dq.push_back({1'b0, 8'(8'h40 + i), 8'h00});
        end
        run(28, 1'b1);
        chk("alt_count", 32'(order_q.size()), 32'd6);
        for (int i = 0; i < order_q.size() && i < 6; i++)
            chk($sformatf("alt_order%0d", i), 32'(order_q[i]), 32'(exp_ord[i]));

        // Reset pulsed in the middle of a CPU write access.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h77;
        @(posedge clk); #1;
        cpu_req = 1'b1;
        @(negedge clk);
        chk("midrst_gnt_before", 32'(cpu_gnt), 32'd1);
        chk("midrst_we_before", 32'(mem_we), 32'd1);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("midrst_no_done", {30'd0, cpu_done, dma_done}, 32'd0);
        end
        cq.push_back({1'b0, 8'h20, 8'h00});
        dq.push_back({1'b1, 8'h21, 8'h99});
        run(12, 1'b1);
        chk("midrst_count", 32'(order_q.size()), 32'd2);
        if (order_q.size() > 0) chk("midrst_cpu_first", 32'(order_q[0]), 32'd0);

        // Zero-wait-state build: one grant cycle, done at cycle 2.
        zdn = 0;
        @(posedge clk); #1;
        z_cpu_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                if (zdn) z_cpu_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("ws0_gnt_c%0d", c), 32'(z_cpu_gnt), 32'(c == 1));
            chk($sformatf("ws0_done_c%0d", c), 32'(z_cpu_done), 32'(c == 2));
            zdn = z_cpu_done;
        end
        chk("ws0_rdata", 32'(z_cpu_rdata), 32'h9E);

        // Randomized traffic on both ports with random issue gaps.
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rop.we = 1'($urandom_range(0, 1)); rop.addr = 8'($urandom_range(0, 15)); rop.wdata = 8'($urandom);
            cq.push_back(rop);
            rop.we = 1'($urandom_range(0, 1)); rop.addr = 8'($urandom_range(0, 15)); rop.wdata = 8'($urandom);
            dq.push_back(rop);
        end
        run(300, 1'b0);
        chk("rand_all_served", 32'(cq.size() + dq.size() + int'(c_act) + int'(d_act)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
